seven_seg_scanner: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display. It sequences a single shared `seven_seg_driver` across `NUM_DIGITS` digits:
- presents one hex nibble at a time on `digit`;
- drives the matching active-low anode enable;
- inserts a blanking gap between digits to suppress ghosting.

Display data is loaded through a valid/ready write port into a shadow buffer, which is committed only at frame boundaries so a frame never shows mixed old/new values.

---
 rtl/seven_seg_scanner.sv | 112 +++++++++++
 tb/tb_seven_seg_scanner.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Scan controller for a multiplexed common-anode seven-segment display.
// Double-buffered display data is committed only at frame boundaries.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    input  logic                    lz_blank,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, ON} phase_t;

    phase_t                  state, state_nxt;
    logic [4*NUM_DIGITS-1:0] active, active_nxt, pending;
    logic                    pending_valid;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    slot_end, frame_end, accept;
    logic [NUM_DIGITS:0]     zero_above;
    logic [NUM_DIGITS-1:0]   an_n_nxt;
    logic [3:0]              digit_nxt;
    logic                    frame_done_nxt;

    assign wr_ready = !pending_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BLANK;
        else       state <= state_nxt;
    end

    // Output registers are loaded from next-cycle state so they line up with cnt/idx.
    always_comb begin
        state_nxt      = state;
        slot_end       = (cnt == CNT_LAST);
        frame_end      = slot_end && (idx == IDX_LAST);
        accept         = wr_en && !pending_valid;
        cnt_nxt        = slot_end ? '0 : cnt + 1'b1;
        idx_nxt        = idx;
        active_nxt     = active;
        an_n_nxt       = '1;
        digit_nxt      = '0;
        zero_above     = '0;

        if (slot_end) idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

        if (frame_end) begin
            if (accept)             active_nxt = wr_data;
            else if (pending_valid) active_nxt = pending;
        end

        case (state)
            BLANK: if (cnt == BLANK_LAST) state_nxt = ON;
            ON:    if (slot_end)          state_nxt = BLANK;
            default:                      state_nxt = BLANK;
        endcase

        zero_above[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && (active_nxt[4*i +: 4] == 4'h0);

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                digit_nxt = active_nxt[4*i +: 4];
                if (state_nxt == ON && !(lz_blank && i != 0 && zero_above[i]))
                    an_n_nxt[i] = 1'b0;
            end
        end

        frame_done_nxt = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            cnt           <= '0;
            idx           <= '0;
            an_n          <= '1;
            digit         <= '0;
            frame_done    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            active     <= active_nxt;
            an_n       <= an_n_nxt;
            digit      <= digit_nxt;
            frame_done <= frame_done_nxt;
            if (frame_end) begin
                pending_valid <= 1'b0;
            end else if (accept) begin
                pending       <= wr_data;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: time-based reference model checked every cycle,
// plus literal spot checks at hand-computed cycles.
module tb_seven_seg_scanner;
    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [4*N-1:0] wr_data = '0;
    logic          wr_ready;
    logic          lz_blank = 1'b0;
    logic [3:0]    digit;
    logic [N-1:0]  an_n;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    seven_seg_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .lz_blank(lz_blank), .digit(digit),
        .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: m_t is the cycle number since reset release.
    int             m_t = 0;
    logic [4*N-1:0] m_active = '0;
    logic [4*N-1:0] m_pending = '0;
    bit             m_pv = 0;
    bit             m_lz = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_active = '0; m_pv = 0; m_lz = 0;
        end else begin
            if (m_t % (N*P) == N*P - 1) begin
                if (wr_en && !m_pv) m_active = wr_data;
                else if (m_pv)      m_active = m_pending;
                m_pv = 0;
            end else if (wr_en && !m_pv) begin
                m_pending = wr_data;
                m_pv = 1;
            end
            m_lz = lz_blank;
            m_t++;
        end
    end

    function automatic logic [N-1:0] exp_an(int t, logic [4*N-1:0] act, bit lz);
        int slot = (t / P) % N;
        logic [N-1:0] r = '1;
        if (t % P >= B && !(lz && slot >= 1 && (act >> (4*slot)) == 0))
            r[slot] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] exp_digit(int t, logic [4*N-1:0] act);
        return 4'((act >> (4*((t / P) % N))) & 16'hF);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, m_t, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_an_n", 32'(an_n), 32'((1 << N) - 1));
            chk("rst_digit", 32'(digit), 32'h0);
            chk("rst_frame_done", 32'(frame_done), 32'h0);
            chk("rst_wr_ready", 32'(wr_ready), 32'h1);
        end else begin
            chk("an_n", 32'(an_n), 32'(exp_an(m_t, m_active, m_lz)));
            chk("digit", 32'(digit), 32'(exp_digit(m_t, m_active)));
            chk("frame_done", 32'(frame_done), 32'(m_t % (N*P) == N*P - 1));
            chk("wr_ready", 32'(wr_ready), 32'(!m_pv));
        end
    end

    task automatic at_cycle(int k);
        int guard = 0;
        while (m_t < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (m_t < k) begin
            $display("FAIL at_cycle timeout: got %0d expected %0d", m_t, k);
            n_fail++;
        end
    endtask

    task automatic write(int k, logic [4*N-1:0] d);
        at_cycle(k);
        wr_en = 1'b1; wr_data = d;
        at_cycle(k + 1);
        wr_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        at_cycle(1);  chk("lit_an_c1", 32'(an_n), 32'hF);
        at_cycle(2);  chk("lit_an_c2", 32'(an_n), 32'hE);
        at_cycle(10); chk("lit_an_c10", 32'(an_n), 32'hD);
        at_cycle(31); chk("lit_fd_c31", 32'(frame_done), 32'h1);
        at_cycle(63); chk("lit_fd_c63", 32'(frame_done), 32'h1);

        write(69, 16'h1A2F);
        chk("lit_ready_low", 32'(wr_ready), 32'h0);
        at_cycle(96);  chk("lit_ready_high", 32'(wr_ready), 32'h1);
                       chk("lit_dig_s0", 32'(digit), 32'hF);
        at_cycle(104); chk("lit_dig_s1", 32'(digit), 32'h2);
        at_cycle(112); chk("lit_dig_s2", 32'(digit), 32'hA);
        at_cycle(120); chk("lit_dig_s3", 32'(digit), 32'h1);

        write(127, 16'h0042);
        chk("lit_bypass_ready", 32'(wr_ready), 32'h1);
        chk("lit_bypass_dig", 32'(digit), 32'h2);

        write(130, 16'h1111);
        at_cycle(132); chk("lit_bp_ready", 32'(wr_ready), 32'h0);
        write(132, 16'h2222);
        at_cycle(136); chk("lit_bypass_dig1", 32'(digit), 32'h4);
        at_cycle(160); chk("lit_bp_dig0", 32'(digit), 32'h1);
        at_cycle(176); chk("lit_bp_dig2", 32'(digit), 32'h1);
        at_cycle(192); chk("lit_bp_lost", 32'(digit), 32'h1);

        write(195, 16'h0040);
        at_cycle(200); lz_blank = 1'b1;
        at_cycle(226); chk("lit_lz_an0", 32'(an_n), 32'hE);
                       chk("lit_lz_dig0", 32'(digit), 32'h0);
        at_cycle(234); chk("lit_lz_an1", 32'(an_n), 32'hD);
                       chk("lit_lz_dig1", 32'(digit), 32'h4);
        at_cycle(240); chk("lit_lz_an2_blank", 32'(an_n), 32'hF);
        at_cycle(242); chk("lit_lz_an2", 32'(an_n), 32'hF);
        at_cycle(250); chk("lit_lz_an3", 32'(an_n), 32'hF);

        write(260, 16'h0000);
        at_cycle(290); chk("lit_lz0_an0", 32'(an_n), 32'hE);
        write(295, 16'h00FF);
        at_cycle(298); chk("lit_lz0_an1", 32'(an_n), 32'hF);

        at_cycle(301);
        #1 rst = 1'b1;
        #1 chk("lit_rst_an", 32'(an_n), 32'hF);
        chk("lit_rst_ready", 32'(wr_ready), 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("lit_rel_dig", 32'(digit), 32'h0);
        at_cycle(34); chk("lit_discard_dig", 32'(digit), 32'h0);
                      chk("lit_discard_an", 32'(an_n), 32'hE);
        at_cycle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
